dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single-port data memory between the core load/store path (c_*)
//  and a debug/loader port (d_*), e.g. a program loader or a bench memory inspector.
//  - Per-requester valid/ready request channel and a one-cycle rsp_valid read return.
//  - Round-robin fairness when both requesters are valid.
//  - Memory side is synchronous: read data is returned one cycle after the access; writes commit on the access edge.
// PARAMETERS
//  ADDR_WIDTH   32   byte address width, passed through unmodified
//  DATA_WIDTH   32   data word width
//  BE_WIDTH     DATA_WIDTH/8   byte-enable width (derived, not overridden)
// PORTS
//  clk            in   1            rising-edge clock, single domain
//  reset          in   1            synchronous, active-high reset
//  {c,d}_req_valid  in   1          request present; payload must stay stable until ready
//  {c,d}_req_ready  out  1          grant; a transfer occurs when valid && ready
//  {c,d}_req_we     in   1          1 = write, 0 = read
//  {c,d}_req_addr   in   ADDR_WIDTH byte address
//  {c,d}_req_wdata  in   DATA_WIDTH write data
//  {c,d}_req_be     in   BE_WIDTH   byte enables for writes (ignored on reads)
//  {c,d}_rsp_valid  out  1          one-cycle pulse, read data valid
//  {c,d}_rsp_rdata  out  DATA_WIDTH read data, 0 when rsp_valid = 0
//  m_en           out  1            memory access strobe
//  m_we           out  1            memory write enable (qualified by m_en)
//  m_addr         out  ADDR_WIDTH   memory address
//  m_wdata        out  DATA_WIDTH   memory write data
//  m_be           out  BE_WIDTH     memory byte enables
//  m_rdata        in   DATA_WIDTH   memory read data, valid the cycle after a read access
// BEHAVIOUR
//  - Reset values:
//    - state = IDLE, rr_ptr = 0 (core favoured first), owner = 0.
//    - All ready, rsp_valid and m_en outputs = 0; m_we = 0.
//    - All data outputs = 0.
//  - FSM states: IDLE and RD_WAIT.
//  - IDLE arbitration:
//    - Only c valid -> grant c. Only d valid -> grant d.
//    - Both valid -> grant the port selected by rr_ptr (0 = c, 1 = d).
//    - The grant is combinational in the same cycle: winner's ready = 1, and m_en = 1.
//    - m_we, m_addr, m_wdata and m_be are muxed from the winner.
//    - The loser's ready = 0.
//    - No valid -> m_en = 0, m_* data outputs = 0.
//  - rr_ptr update: on every grant, rr_ptr <= ~winner.
//    - A requester waiting with valid high therefore gets at most one other grant ahead of it.
//  - Write grant: the access commits that edge; state remains IDLE; no response is generated.
//    - Back-to-back writes sustain 1 per cycle.
//  - Read grant: owner <= winner; state -> RD_WAIT.
//  - RD_WAIT:
//    - Both ready outputs = 0, m_en = 0.
//    - owner's rsp_valid = 1 and rsp_rdata = m_rdata; the other port's rsp_valid = 0.
//    - state -> IDLE next edge. Reads therefore sustain at most 1 per 2 cycles per arbiter.
//  - Simultaneous events:
//    - A request asserted during RD_WAIT waits and competes in the following IDLE cycle.
//    - rr_ptr is unaffected by waiting.
//  - Reset mid-read (reset high in RD_WAIT): the pending response is dropped, so no rsp_valid pulse is produced.
//    - All registers return to their reset values on that edge.
//  - Address and data are not checked or aligned; width rules are pure pass-through.
//  - The block never asserts ready to a port whose valid is 0.
// TESTING
//  1. Reset held 3 cycles:
//     -> all ready, rsp_valid and m_en = 0 during reset and on the first cycle after (no valid).
//  2. c writes 0x10 to addr 0x00, be = 4'hF:
//     -> c_req_ready = 1 same cycle, m_we = 1, m_addr = 0x00.
//     -> Then c reads 0x00: c_rsp_valid pulses 1 cycle later with 0x10.
//  3. c and d both valid with reads from reset:
//     -> c granted first (d_req_ready = 0), d granted in the next IDLE cycle.
//     -> Responses are routed to the correct port only.
//  4. c and d both continuously valid with writes for 6 cycles:
//     -> grants alternate c,d,c,d,c,d.
//     -> Neither port waits more than 1 cycle.
//  5. d read issued; reset asserted in the RD_WAIT cycle:
//     -> d_rsp_valid stays 0; state IDLE, rr_ptr = 0 afterwards.
//  6. d requests during c's RD_WAIT:
//     -> d_req_ready = 0 in RD_WAIT; d granted the next cycle.
//     -> c_rsp_rdata = m_rdata, and d_rsp_rdata = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data memory port
// between the core load/store path (c_*) and a debug/loader port (d_*).
module dmem_arbiter #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req_valid,
  output logic                  c_req_ready,
  input  logic                  c_req_we,
  input  logic [ADDR_WIDTH-1:0] c_req_addr,
  input  logic [DATA_WIDTH-1:0] c_req_wdata,
  input  logic [BE_WIDTH-1:0]   c_req_be,
  output logic                  c_rsp_valid,
  output logic [DATA_WIDTH-1:0] c_rsp_rdata,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic [BE_WIDTH-1:0]   d_req_be,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [BE_WIDTH-1:0]   m_be,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t state_q, state_d;
  logic   rr_q, rr_d;
  logic   owner_q, owner_d;
  logic   gnt_c, gnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Outputs are forced quiet while reset is high so a read caught
  // mid-flight never leaks a response pulse.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    gnt_c       = 1'b0;
    gnt_d       = 1'b0;
    c_req_ready = 1'b0;
    d_req_ready = 1'b0;
    c_rsp_valid = 1'b0;
    d_rsp_valid = 1'b0;
    c_rsp_rdata = '0;
    d_rsp_rdata = '0;
    m_en        = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_be        = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          gnt_c = c_req_valid && (!d_req_valid || !rr_q);
          gnt_d = d_req_valid && !gnt_c;
          c_req_ready = gnt_c;
          d_req_ready = gnt_d;
          if (gnt_c) begin
            m_we    = c_req_we;
            m_addr  = c_req_addr;
            m_wdata = c_req_wdata;
            m_be    = c_req_be;
          end else if (gnt_d) begin
            m_we    = d_req_we;
            m_addr  = d_req_addr;
            m_wdata = d_req_wdata;
            m_be    = d_req_be;
          end
          if (gnt_c || gnt_d) begin
            m_en = 1'b1;
            rr_d = !gnt_d;
            if (!m_we) begin
              owner_d = gnt_d;
              state_d = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          state_d = IDLE;
          if (owner_q) begin
            d_rsp_valid = 1'b1;
            d_rsp_rdata = m_rdata;
          end else begin
            c_rsp_valid = 1'b1;
            c_rsp_rdata = m_rdata;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req_valid, c_req_ready, c_req_we;
  logic [31:0] c_req_addr, c_req_wdata;
  logic [3:0]  c_req_be;
  logic        c_rsp_valid;
  logic [31:0] c_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [3:0]  d_req_be;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
    .c_req_we(c_req_we), .c_req_addr(c_req_addr),
    .c_req_wdata(c_req_wdata), .c_req_be(c_req_be),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_rdata(m_rdata)
  );

  // Environment memory: 16 words, reacts only to the m_* port
  logic [31:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    m_rdata = '0;
  end
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr[5:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= mem[m_addr[5:2]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one pending-read slot, a favoured-port pointer,
  // an expected memory image and a per-port count of grants overtaking it.
  initial begin
    int          pend;
    int          fav;
    int          w;
    int          skip [2];
    logic [31:0] emem [16];
    logic [31:0] prd;
    logic        v [2];
    logic        we [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    logic        e_rdy [2];
    logic        e_rv [2];
    logic [31:0] e_rd [2];
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    pend = -1;
    fav  = 0;
    prd  = '0;
    skip[0] = 0;
    skip[1] = 0;
    for (int i = 0; i < 16; i++) emem[i] = '0;
    forever begin
      @(negedge clk);
      v[0] = c_req_valid; we[0] = c_req_we; ad[0] = c_req_addr;
      wd[0] = c_req_wdata; be[0] = c_req_be;
      v[1] = d_req_valid; we[1] = d_req_we; ad[1] = d_req_addr;
      wd[1] = d_req_wdata; be[1] = d_req_be;
      for (int p = 0; p < 2; p++) begin
        e_rdy[p] = 0; e_rv[p] = 0; e_rd[p] = '0;
      end
      e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_be = '0;
      if (reset) begin
        pend = -1;
        fav  = 0;
        skip[0] = 0;
        skip[1] = 0;
      end else if (pend >= 0) begin
        e_rv[pend] = 1;
        e_rd[pend] = prd;
        pend = -1;
      end else begin
        w = -1;
        if (v[0] && v[1]) w = fav;
        else if (v[0]) w = 0;
        else if (v[1]) w = 1;
        if (w >= 0) begin
          e_rdy[w] = 1;
          e_en   = 1;
          e_we   = we[w];
          e_addr = ad[w];
          e_wd   = wd[w];
          e_be   = be[w];
          fav    = 1 - w;
          skip[w] = 0;
          if (v[1-w]) begin
            skip[1-w]++;
            chk("fairness", 32'(skip[1-w] <= 1), 32'd1);
          end
          if (we[w]) begin
            for (int b = 0; b < 4; b++)
              if (be[w][b]) emem[ad[w][5:2]][8*b +: 8] = wd[w][8*b +: 8];
          end else begin
            pend = w;
            prd  = emem[ad[w][5:2]];
          end
        end
      end
      chk("c_req_ready", 32'(c_req_ready), 32'(e_rdy[0]));
      chk("d_req_ready", 32'(d_req_ready), 32'(e_rdy[1]));
      chk("c_rsp_valid", 32'(c_rsp_valid), 32'(e_rv[0]));
      chk("d_rsp_valid", 32'(d_rsp_valid), 32'(e_rv[1]));
      chk("c_rsp_rdata", c_rsp_rdata, e_rd[0]);
      chk("d_rsp_rdata", d_rsp_rdata, e_rd[1]);
      chk("m_en", 32'(m_en), 32'(e_en));
      chk("m_we", 32'(m_we), 32'(e_we));
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wd);
      chk("m_be", 32'(m_be), 32'(e_be));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(output logic v, output logic we,
                          output logic [31:0] a, output logic [31:0] wd,
                          output logic [3:0] be);
    v  = ($urandom_range(0, 2) != 0);
    we = 1'($urandom_range(0, 1));
    a  = 32'($urandom_range(0, 15)) << 2;
    wd = $urandom;
    be = 4'($urandom);
  endtask

  initial begin
    int   g;
    logic fc, fd;
    reset = 1;
    c_req_valid = 0; c_req_we = 0; c_req_addr = '0;
    c_req_wdata = '0; c_req_be = '0;
    d_req_valid = 0; d_req_we = 0; d_req_addr = '0;
    d_req_wdata = '0; d_req_be = '0;

    // 1: reset held 3 cycles, then one idle cycle
    repeat (3) begin
      @(negedge clk);
      chk("t1 rst ready", 32'({c_req_ready, d_req_ready}), 32'd0);
      chk("t1 rst rsp/en", 32'({c_rsp_valid, d_rsp_valid, m_en}), 32'd0);
    end
    step();
    reset = 0;
    @(negedge clk);
    chk("t1 idle", 32'({c_req_ready, d_req_ready, c_rsp_valid,
                        d_rsp_valid, m_en}), 32'd0);

    // 2: c write then read back
    step();
    c_req_valid = 1; c_req_we = 1; c_req_addr = 32'h0;
    c_req_wdata = 32'h10; c_req_be = 4'hF;
    @(negedge clk);
    chk("t2 wr ready", 32'(c_req_ready), 32'd1);
    chk("t2 wr m_we", 32'(m_we), 32'd1);
    chk("t2 wr m_addr", m_addr, 32'h0);
    step();
    c_req_we = 0;
    @(negedge clk);
    chk("t2 rd ready", 32'(c_req_ready), 32'd1);
    step();
    c_req_valid = 0;
    @(negedge clk);
    chk("t2 rsp valid", 32'(c_rsp_valid), 32'd1);
    chk("t2 rsp data", c_rsp_rdata, 32'h10);

    // 3: both read from reset
    step();
    reset = 1;
    step();
    reset = 0;
    c_req_valid = 1; c_req_we = 0; c_req_addr = 32'h0;
    d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h0;
    @(negedge clk);
    chk("t3 c first", 32'({c_req_ready, d_req_ready}), 32'b10);
    step();
    c_req_valid = 0;
    @(negedge clk);
    chk("t3 wait d_ready", 32'(d_req_ready), 32'd0);
    chk("t3 c rsp", 32'({c_rsp_valid, d_rsp_valid}), 32'b10);
    step();
    @(negedge clk);
    chk("t3 d grant", 32'(d_req_ready), 32'd1);
    step();
    d_req_valid = 0;
    @(negedge clk);
    chk("t3 d rsp", 32'({c_rsp_valid, d_rsp_valid}), 32'b01);
    chk("t3 d rdata", d_rsp_rdata, 32'h10);

    // 4: both continuously writing alternate grants
    step();
    reset = 1;
    step();
    reset = 0;
    c_req_valid = 1; c_req_we = 1; c_req_addr = 32'h8;
    c_req_wdata = 32'hC000_0000; c_req_be = 4'hF;
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'hC;
    d_req_wdata = 32'hD000_0000; d_req_be = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g = c_req_ready ? 0 : (d_req_ready ? 1 : 2);
      chk("t4 grant", 32'(g), 32'(i % 2));
      step();
      if (g == 0) c_req_wdata = c_req_wdata + 1;
      if (g == 1) d_req_wdata = d_req_wdata + 1;
    end
    c_req_valid = 0;
    d_req_valid = 0;

    // 5: reset during d's RD_WAIT drops the response
    step();
    reset = 1;
    step();
    reset = 0;
    d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h0;
    @(negedge clk);
    chk("t5 d grant", 32'(d_req_ready), 32'd1);
    step();
    d_req_valid = 0;
    reset = 1;
    @(negedge clk);
    chk("t5 no rsp", 32'(d_rsp_valid), 32'd0);
    step();
    reset = 0;
    c_req_valid = 1; c_req_we = 1; c_req_addr = 32'h10;
    c_req_wdata = 32'h1; c_req_be = 4'hF;
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h14;
    d_req_wdata = 32'h2; d_req_be = 4'hF;
    @(negedge clk);
    chk("t5 rr cleared", 32'({c_req_ready, d_req_ready}), 32'b10);
    step();
    c_req_valid = 0;
    @(negedge clk);
    chk("t5 d next", 32'(d_req_ready), 32'd1);
    step();
    d_req_valid = 0;

    // 6: d request arriving during c's RD_WAIT
    c_req_valid = 1; c_req_we = 0; c_req_addr = 32'h0;
    @(negedge clk);
    chk("t6 c grant", 32'(c_req_ready), 32'd1);
    step();
    c_req_valid = 0;
    d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h8;
    @(negedge clk);
    chk("t6 d held", 32'(d_req_ready), 32'd0);
    chk("t6 c rsp", 32'(c_rsp_valid), 32'd1);
    chk("t6 c=m_rdata", c_rsp_rdata, m_rdata);
    chk("t6 c rdata", c_rsp_rdata, 32'h10);
    chk("t6 d rdata 0", d_rsp_rdata, 32'h0);
    step();
    @(negedge clk);
    chk("t6 d grant", 32'(d_req_ready), 32'd1);
    step();
    d_req_valid = 0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      fc = c_req_valid && c_req_ready;
      fd = d_req_valid && d_req_ready;
      step();
      reset = ($urandom_range(0, 99) == 0);
      if (!c_req_valid || fc)
        rand_req(c_req_valid, c_req_we, c_req_addr, c_req_wdata, c_req_be);
      if (!d_req_valid || fd)
        rand_req(d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be);
    end
    step();
    c_req_valid = 0;
    d_req_valid = 0;
    reset = 0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
